// File: rtl/trojan_scan_pkg.sv
// Shared types and constants for the trojan scan controllers.
// Holds the FSM state encoding, LFSR/MISR polynomials and their step functions.
package trojan_scan_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SCRST = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      FIN   = 3'd4
   } scan_state_e;

   // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] MISR_POLY    = 16'h002D;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

   function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic bit_in);
      return {sig[14:0], 1'b0} ^ {15'b0, bit_in} ^ (sig[15] ? MISR_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/scan_lfsr16.sv
// 16-bit Fibonacci pattern LFSR with seed load; a zero seed falls back to RESET_SEED
// so the register can never lock up in the all-zero state.
module scan_lfsr16
   import trojan_scan_pkg::*;
#(
   parameter logic [15:0] RESET_SEED = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        advance,
   input  logic [15:0] seed,
   output logic [15:0] state
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = (seed == 16'h0000) ? RESET_SEED : seed;
      end else if (advance) begin
         lfsr_d = lfsr_step(lfsr_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= RESET_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state = lfsr_q;

endmodule

// File: rtl/trojan_scan_sequencer.sv
// Reset-pulses a DFF subcircuit, streams LFSR patterns into it and compares its
// delayed output against a golden model, accumulating mismatches and a MISR signature.
module trojan_scan_sequencer
   import trojan_scan_pkg::*;
#(
   parameter int          IN_W    = 6,
   parameter int          LAT     = 1,
   parameter int          CNT_W   = 16,
   parameter int          RST_CYC = 2,
   parameter logic [15:0] SEED    = DEFAULT_SEED
) (
   input  logic             core_clk,
   input  logic             core_rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] num_patterns,
   input  logic [15:0]      seed,
   output logic [IN_W-1:0]  sc_in,
   output logic             sc_rst_n,
   input  logic             sc_out,
   input  logic             gold_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] first_fail,
   output logic [15:0]      signature
);

   localparam logic [CNT_W-1:0] CNT_ONES = '1;
   localparam int               WAIT_MAX = (RST_CYC > LAT) ? RST_CYC : LAT;
   localparam int               WAIT_W   = $clog2(WAIT_MAX + 1);

   scan_state_e state_q, state_d;

   logic [CNT_W-1:0]  num_q, num_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  mm_q, mm_d;
   logic [CNT_W-1:0]  ff_q, ff_d;
   logic [15:0]       sig_q, sig_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              sc_rst_n_q, sc_rst_n_d;
   logic [IN_W-1:0]   sc_hold_q, sc_hold_d;

   logic              pv_q   [LAT];
   logic              pv_d   [LAT];
   logic [CNT_W-1:0]  pidx_q [LAT];
   logic [CNT_W-1:0]  pidx_d [LAT];

   logic [15:0]       lfsr_state;
   logic              lfsr_load;
   logic              lfsr_adv;
   logic              lfsr_unused;

   logic              start_run;
   logic              last_issue;
   logic              rst_wait_done;
   logic              drain_done;
   logic              tail_valid;
   logic [CNT_W-1:0]  tail_idx;

   scan_lfsr16 #(
      .RESET_SEED (SEED)
   ) u_lfsr (
      .clk     (core_clk),
      .rst     (core_rst),
      .load    (lfsr_load),
      .advance (lfsr_adv),
      .seed    (seed),
      .state   (lfsr_state)
   );

   // Only the low IN_W bits drive the subcircuit; the rest just keep the sequence long.
   assign lfsr_unused = ^lfsr_state;

   assign start_run     = (state_q == IDLE) && start && !abort;
   assign last_issue    = (idx_q == (num_q - CNT_W'(1)));
   assign rst_wait_done = (wait_q == WAIT_W'(RST_CYC - 1));
   assign drain_done    = (wait_q == WAIT_W'(LAT - 1));
   assign tail_valid    = pv_q[LAT-1];
   assign tail_idx      = pidx_q[LAT-1];

   // ---------------- FSM: state register ----------------
   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = SCRST;
            SCRST:   if (rst_wait_done) state_d = (num_q == '0) ? FIN : RUN;
            RUN:     if (last_issue) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy      = (state_q != IDLE);
      done      = (state_q == FIN);
      lfsr_load = start_run;
      lfsr_adv  = (state_q == RUN);
      case (state_q)
         IDLE:    sc_in = sc_hold_q;
         RUN:     sc_in = lfsr_state[IN_W-1:0];
         default: sc_in = '0;
      endcase
   end

   // ---------------- compare pipeline ----------------
   genvar gi;
   generate
      for (gi = 0; gi < LAT; gi++) begin : g_pipe
         if (gi == 0) begin : g_head
            assign pv_d[gi]   = (state_q == RUN) && !abort;
            assign pidx_d[gi] = idx_q;
         end else begin : g_body
            assign pv_d[gi]   = pv_q[gi-1] && !abort;
            assign pidx_d[gi] = pidx_q[gi-1];
         end

         always_ff @(posedge core_clk or posedge core_rst) begin
            if (core_rst) begin
               pv_q[gi]   <= 1'b0;
               pidx_q[gi] <= '0;
            end else begin
               pv_q[gi]   <= pv_d[gi];
               pidx_q[gi] <= pidx_d[gi];
            end
         end
      end
   endgenerate

   // ---------------- run bookkeeping and results ----------------
   always_comb begin
      num_d      = start_run ? num_patterns : num_q;
      sc_hold_d  = sc_in;
      // Registered from next state so the reset pulse is clean and spans exactly the SCRST cycles.
      sc_rst_n_d = (state_d != SCRST);

      idx_d = idx_q;
      if (start_run) begin
         idx_d = '0;
      end else if (state_q == RUN) begin
         idx_d = idx_q + CNT_W'(1);
      end

      wait_d = '0;
      if ((state_d == state_q) && ((state_q == SCRST) || (state_q == DRAIN))) begin
         wait_d = wait_q + WAIT_W'(1);
      end

      mm_d  = mm_q;
      ff_d  = ff_q;
      sig_d = sig_q;
      if (start_run) begin
         mm_d  = '0;
         ff_d  = CNT_ONES;
         sig_d = 16'h0000;
      end else if (tail_valid) begin
         if (sc_out != gold_out) begin
            if (mm_q != CNT_ONES) mm_d = mm_q + CNT_W'(1);
            if (ff_q == CNT_ONES) ff_d = tail_idx;
         end
         sig_d = misr_step(sig_q, sc_out);
      end
   end

   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         num_q      <= '0;
         idx_q      <= '0;
         mm_q       <= '0;
         ff_q       <= CNT_ONES;
         sig_q      <= 16'h0000;
         wait_q     <= '0;
         sc_rst_n_q <= 1'b0;
         sc_hold_q  <= '0;
      end else begin
         num_q      <= num_d;
         idx_q      <= idx_d;
         mm_q       <= mm_d;
         ff_q       <= ff_d;
         sig_q      <= sig_d;
         wait_q     <= wait_d;
         sc_rst_n_q <= sc_rst_n_d;
         sc_hold_q  <= sc_hold_d;
      end
   end

   assign sc_rst_n     = sc_rst_n_q;
   assign mismatch_cnt = mm_q;
   assign first_fail   = ff_q;
   assign signature    = sig_q;

endmodule

// File: tb/tb_trojan_scan_sequencer.sv
// Bench for trojan_scan_sequencer: a parity DFF stand-in for the subcircuit, a golden
// model with injectable output flips, and a reference model of the expected run results.
module tb_trojan_scan_sequencer;

   localparam int IN_W    = 6;
   localparam int LAT     = 1;
   localparam int CNT_W   = 16;
   localparam int RST_CYC = 2;

   typedef struct {
      int          n;
      logic [15:0] sd;
      int          fa;
      int          fb;
      logic [15:0] mm;
      logic [15:0] ff;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // main DUT signals
   logic              start, abort;
   logic [CNT_W-1:0]  num_patterns;
   logic [15:0]       seed;
   logic [IN_W-1:0]   sc_in;
   logic              sc_rst_n;
   logic              sc_out = 1'b0;
   logic              gold_out = 1'b0;
   logic              busy, done;
   logic [CNT_W-1:0]  mismatch_cnt, first_fail;
   logic [15:0]       signature;

   // narrow-counter DUT signals
   logic              start4, abort4;
   logic [3:0]        num4;
   logic [15:0]       seed4;
   logic [IN_W-1:0]   sc_in4;
   logic              sc_rst_n4;
   logic              sc_out4 = 1'b0;
   logic              gold4 = 1'b0;
   logic              busy4, done4;
   logic [3:0]        mm4, ff4;
   logic [15:0]       sig4;

   logic        flip_tbl [256];
   logic [15:0] pcount = 16'h0;
   logic [15:0] exp_pat [256];

   int n_total = 0;
   int n_pass  = 0;

   trojan_scan_sequencer #(
      .IN_W(IN_W), .LAT(LAT), .CNT_W(CNT_W), .RST_CYC(RST_CYC), .SEED(16'hACE1)
   ) dut (
      .core_clk(clk), .core_rst(rst), .start(start), .abort(abort),
      .num_patterns(num_patterns), .seed(seed), .sc_in(sc_in), .sc_rst_n(sc_rst_n),
      .sc_out(sc_out), .gold_out(gold_out), .busy(busy), .done(done),
      .mismatch_cnt(mismatch_cnt), .first_fail(first_fail), .signature(signature)
   );

   trojan_scan_sequencer #(
      .IN_W(IN_W), .LAT(LAT), .CNT_W(4), .RST_CYC(RST_CYC), .SEED(16'hACE1)
   ) dut4 (
      .core_clk(clk), .core_rst(rst), .start(start4), .abort(abort4),
      .num_patterns(num4), .seed(seed4), .sc_in(sc_in4), .sc_rst_n(sc_rst_n4),
      .sc_out(sc_out4), .gold_out(gold4), .busy(busy4), .done(done4),
      .mismatch_cnt(mm4), .first_fail(ff4), .signature(sig4)
   );

   // Subcircuit stand-in: one register stage computing parity of the applied pattern.
   // The golden model matches it except where flip_tbl marks the pattern index.
   always @(posedge clk) begin
      if (!sc_rst_n) begin
         sc_out   <= 1'b0;
         gold_out <= 1'b0;
         pcount   <= 16'h0;
      end else begin
         sc_out   <= ^sc_in;
         gold_out <= (^sc_in) ^ flip_tbl[pcount[7:0]];
         pcount   <= pcount + 16'h1;
      end
   end

   always @(posedge clk) begin
      if (!sc_rst_n4) begin
         sc_out4 <= 1'b0;
         gold4   <= 1'b0;
      end else begin
         sc_out4 <= ^sc_in4;
         gold4   <= ~(^sc_in4);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", nm, act, req);
   endtask

   task automatic clear_flips();
      for (int i = 0; i < 256; i++) flip_tbl[i] = 1'b0;
   endtask

   // Reference: pattern k is the seed stepped k times; each compared output is the
   // parity of the pattern's low IN_W bits; flipped indices count as mismatches.
   task automatic model(input int n, input logic [15:0] sd,
                        output logic [15:0] emm, output logic [15:0] eff, output logic [15:0] esig);
      logic [15:0] x;
      logic        o;
      x    = (sd == 16'h0) ? 16'hACE1 : sd;
      emm  = 16'h0;
      eff  = 16'hFFFF;
      esig = 16'h0;
      for (int i = 0; i < n; i++) begin
         exp_pat[i] = x;
         o = ^x[IN_W-1:0];
         if (flip_tbl[i]) begin
            if (emm != 16'hFFFF) emm = emm + 16'h1;
            if (eff == 16'hFFFF) eff = 16'(i);
         end
         esig = {esig[14:0], 1'b0} ^ {15'b0, o} ^ (esig[15] ? 16'h002D : 16'h0000);
         x = {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
      end
   endtask

   // Called on a negedge; returns on the negedge after done.
   task automatic do_run(input string nm, input int n, input logic [15:0] sd, input int restart_at,
                         output logic [15:0] got_mm, output logic [15:0] got_ff);
      logic [15:0] emm, eff, esig, got_sig;
      int rstlow, seq_err, done_at, exp_done;
      model(n, sd, emm, eff, esig);
      rstlow  = 0;
      seq_err = 0;
      done_at = -1;
      got_mm  = 16'hDEAD;
      got_ff  = 16'hDEAD;
      got_sig = 16'hDEAD;
      num_patterns = CNT_W'(n);
      seed  = sd;
      start = 1'b1;
      for (int c = 1; c <= 200 && done_at < 0; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (c == restart_at) begin
            start = 1'b1;
            num_patterns = 16'd30;
         end
         if (c == restart_at + 1) start = 1'b0;
         if (!sc_rst_n) rstlow++;
         if (c > RST_CYC && c <= RST_CYC + n) begin
            if (sc_in !== exp_pat[c-RST_CYC-1][IN_W-1:0]) seq_err++;
         end
         if (done) begin
            done_at = c;
            got_mm  = mismatch_cnt;
            got_ff  = first_fail;
            got_sig = signature;
         end
      end
      exp_done = (n > 0) ? (RST_CYC + n + LAT + 1) : (RST_CYC + 1);
      chk({nm, "_rst_low_cycles"}, 32'(rstlow), 32'(RST_CYC));
      chk({nm, "_sc_in_seq_errors"}, 32'(seq_err), 32'd0);
      chk({nm, "_done_cycle"}, 32'(done_at), 32'(exp_done));
      chk({nm, "_mismatch_model"}, {16'h0, got_mm}, {16'h0, emm});
      chk({nm, "_first_fail_model"}, {16'h0, got_ff}, {16'h0, eff});
      chk({nm, "_signature"}, {16'h0, got_sig}, {16'h0, esig});
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, {31'h0, done}, 32'd0);
      chk({nm, "_idle_after"}, {31'h0, busy}, 32'd0);
      $display("run %s n=%0d seed=%04h done_at=%0d mm=%0d ff=%04h sig=%04h", nm, n, sd,
               done_at, got_mm, got_ff, got_sig);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_busy"}, {31'h0, busy}, 32'd0);
      chk({tag, "_done"}, {31'h0, done}, 32'd0);
      chk({tag, "_sc_rst_n"}, {31'h0, sc_rst_n}, 32'd0);
      chk({tag, "_sc_in"}, 32'(sc_in), 32'd0);
      chk({tag, "_mismatch"}, 32'(mismatch_cnt), 32'd0);
      chk({tag, "_first_fail"}, 32'(first_fail), 32'h0000FFFF);
      chk({tag, "_signature"}, 32'(signature), 32'd0);
      chk({tag, "_busy4"}, {31'h0, busy4}, 32'd0);
      chk({tag, "_mismatch4"}, 32'(mm4), 32'd0);
      chk({tag, "_first_fail4"}, 32'(ff4), 32'hF);
      chk({tag, "_sc_rst_n4"}, {31'h0, sc_rst_n4}, 32'd0);
      $display("reset check %s done", tag);
   endtask

   initial begin
      vec_t        vecs [5];
      logic [15:0] gmm, gff, rsd;
      logic [3:0]  s_mm4, s_ff4;
      int          rn, seen, done_seen;

      vecs[0] = '{n: 8,  sd: 16'h0001, fa: -1, fb: -1, mm: 16'd0, ff: 16'hFFFF};
      vecs[1] = '{n: 20, sd: 16'h1234, fa: 5,  fb: 12, mm: 16'd2, ff: 16'd5};
      vecs[2] = '{n: 0,  sd: 16'h0007, fa: -1, fb: -1, mm: 16'd0, ff: 16'hFFFF};
      vecs[3] = '{n: 5,  sd: 16'h0000, fa: 0,  fb: -1, mm: 16'd1, ff: 16'd0};
      vecs[4] = '{n: 12, sd: 16'hBEEF, fa: 11, fb: 3,  mm: 16'd2, ff: 16'd3};

      clear_flips();
      rst = 1'b1;
      start = 1'b0; abort = 1'b0; num_patterns = '0; seed = 16'h0;
      start4 = 1'b0; abort4 = 1'b0; num4 = 4'd0; seed4 = 16'h0;
      repeat (3) @(negedge clk);
      check_reset("por");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // table-driven runs
      for (int v = 0; v < 5; v++) begin
         clear_flips();
         if (vecs[v].fa >= 0) flip_tbl[vecs[v].fa] = 1'b1;
         if (vecs[v].fb >= 0) flip_tbl[vecs[v].fb] = 1'b1;
         do_run($sformatf("vec%0d", v), vecs[v].n, vecs[v].sd, 0, gmm, gff);
         chk($sformatf("vec%0d_mismatch_tbl", v), {16'h0, gmm}, {16'h0, vecs[v].mm});
         chk($sformatf("vec%0d_first_fail_tbl", v), {16'h0, gff}, {16'h0, vecs[v].ff});
      end

      // start while busy is ignored
      clear_flips();
      do_run("restart_ignored", 6, 16'h0055, 5, gmm, gff);

      // abort during pattern 3 of 10; pattern 1 was flipped and already compared
      clear_flips();
      flip_tbl[1] = 1'b1;
      done_seen = 0;
      num_patterns = 16'd10;
      seed  = 16'h0F0F;
      start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (done) done_seen++;
         if (c == 6) abort = 1'b1;
      end
      @(negedge clk);
      abort = 1'b0;
      if (done) done_seen++;
      chk("abort_busy", {31'h0, busy}, 32'd0);
      chk("abort_no_done", 32'(done_seen), 32'd0);
      chk("abort_partial_mm", 32'(mismatch_cnt), 32'd1);
      chk("abort_partial_ff", 32'(first_fail), 32'd1);
      $display("abort run: mm=%0d ff=%04h busy=%0d", mismatch_cnt, first_fail, busy);
      clear_flips();
      do_run("after_abort", 4, 16'h0F0F, 0, gmm, gff);

      // start and abort together in IDLE: no run
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_idle_busy", {31'h0, busy}, 32'd0);
      @(negedge clk);
      chk("start_abort_idle_busy2", {31'h0, busy}, 32'd0);
      $display("start+abort in idle: busy=%0d", busy);

      // randomized runs against the reference model
      for (int r = 0; r < 6; r++) begin
         clear_flips();
         rn  = int'($urandom_range(1, 40));
         rsd = 16'($urandom);
         for (int i = 0; i < rn; i++) flip_tbl[i] = ($urandom_range(0, 7) == 0);
         do_run($sformatf("rand%0d", r), rn, rsd, 0, gmm, gff);
      end

      // narrow counter: every pattern mismatches
      seen  = 0;
      s_mm4 = 4'h0;
      s_ff4 = 4'hA;
      num4   = 4'd15;
      seed4  = 16'h0003;
      start4 = 1'b1;
      for (int c = 1; c <= 100 && seen == 0; c++) begin
         @(negedge clk);
         if (c == 1) start4 = 1'b0;
         if (done4) begin
            seen  = 1;
            s_mm4 = mm4;
            s_ff4 = ff4;
         end
      end
      chk("cnt4_done_seen", 32'(seen), 32'd1);
      chk("cnt4_saturated", 32'(s_mm4), 32'd15);
      chk("cnt4_first_fail", 32'(s_ff4), 32'd0);
      $display("cnt4 run: mm=%0d ff=%0d", s_mm4, s_ff4);
      @(negedge clk);

      // core_rst in the middle of runs on both DUTs
      start4 = 1'b1;
      num4   = 4'd15;
      clear_flips();
      num_patterns = 16'd20;
      seed  = 16'h0077;
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      start4 = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrun_busy4", {31'h0, busy4}, 32'd1);
      chk("midrun_mm4_nonzero", {31'h0, (mm4 != 4'd0)}, 32'd1);
      chk("midrun_busy", {31'h0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check_reset("midrun");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
